systolic_west_feeder: RTL and testbench

//  Operand skew feeder for the west edge of an N x N systolic MAC array of 4-bit PEs.

---
 rtl/systolic_west_feeder.sv | 128 ++++++++++++
 tb/tb_systolic_west_feeder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_west_feeder.sv
// Operand skew feeder for one edge of an N x N systolic MAC array: buffers K load beats,
// then replays them with row i delayed i cycles and zero-padded, followed by an N-cycle drain.
module systolic_west_feeder #(
    parameter int N  = 4,
    parameter int K  = 4,
    parameter int DW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic [N*DW-1:0] load_data,
    input  logic            start,
    output logic [N*DW-1:0] out_data,
    output logic            out_valid,
    output logic            busy,
    output logic            done
);
    localparam int TW  = $clog2(K + N);
    localparam int LW  = $clog2(K + 1);
    localparam int DCW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_FULL, S_STREAM, S_DRAIN} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [LW-1:0]   r_lcnt;
    logic [TW-1:0]   r_t;
    logic [DCW-1:0]  r_dcnt;
    logic [N*DW-1:0] r_buf [K];

    logic            w_accept;
    logic            w_load_last;
    logic            w_go;
    logic            w_stream_last;
    logic            w_drain_last;
    logic [TW-1:0]   w_col_t;
    logic [N*DW-1:0] w_col;

    assign w_accept      = (r_state == S_IDLE) && load_valid && load_ready;
    assign w_load_last   = w_accept && (r_lcnt == LW'(K - 1));
    assign w_go          = (r_state == S_FULL) && start;
    assign w_stream_last = (r_state == S_STREAM) && (r_t == TW'(K + N - 2));
    assign w_drain_last  = (r_state == S_DRAIN) && (r_dcnt == DCW'(N - 1));

    // Outputs are registered, so compute the column for the t that becomes visible next.
    assign w_col_t = (r_state == S_STREAM) ? r_t + TW'(1) : '0;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic [TW-1:0] w_k;
            logic [DW-1:0] w_lane;
            assign w_k = w_col_t - TW'(gi);
            always_comb begin
                w_lane = '0;
                if (w_col_t >= TW'(gi)) begin
                    for (int k = 0; k < K; k++) begin
                        if (w_k == TW'(k)) begin
                            w_lane = r_buf[k][gi*DW +: DW];
                        end
                    end
                end
            end
            assign w_col[gi*DW +: DW] = w_lane;
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_load_last)   w_state_next = S_FULL;
            S_FULL:   if (w_go)          w_state_next = S_STREAM;
            S_STREAM: if (w_stream_last) w_state_next = S_DRAIN;
            S_DRAIN:  if (w_drain_last)  w_state_next = S_IDLE;
            default:                     w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lcnt     <= '0;
            r_t        <= '0;
            r_dcnt     <= '0;
            load_ready <= 1'b1;
            out_data   <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            for (int k = 0; k < K; k++) begin
                r_buf[k] <= '0;
            end
        end else begin
            for (int k = 0; k < K; k++) begin
                if (w_accept && (r_lcnt == LW'(k))) begin
                    r_buf[k] <= load_data;
                end
            end
            if (w_accept) begin
                r_lcnt <= w_load_last ? '0 : r_lcnt + LW'(1);
            end

            if (w_go) begin
                r_t <= '0;
            end else if (r_state == S_STREAM) begin
                r_t <= w_stream_last ? '0 : r_t + TW'(1);
            end

            if (r_state == S_DRAIN) begin
                r_dcnt <= w_drain_last ? '0 : r_dcnt + DCW'(1);
            end

            load_ready <= (w_state_next == S_IDLE);
            out_valid  <= (w_state_next == S_STREAM);
            busy       <= (w_state_next == S_STREAM) || (w_state_next == S_DRAIN);
            done       <= w_drain_last;
            out_data   <= (w_state_next == S_STREAM) ? w_col : '0;
        end
    end
endmodule

// File: tb/tb_systolic_west_feeder.sv
// Randomized bench for systolic_west_feeder against a matrix-level skew model and a
// behavioural 4x4 PE array fed from the skewed lanes.
module tb_systolic_west_feeder;
    localparam int N  = 4;
    localparam int K  = 4;
    localparam int DW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            load_valid;
    logic            load_ready;
    logic [N*DW-1:0] load_data;
    logic            start;
    logic [N*DW-1:0] out_data;
    logic            out_valid;
    logic            busy;
    logic            done;

    int n_total = 0;
    int n_bad   = 0;
    int a_mat [N][K];
    int acc   [N][N];
    int pa    [N][N];
    int pb    [N][N];
    bit pe_clr = 1'b1;

    always #5 clk = ~clk;

    systolic_west_feeder #(.N(N), .K(K), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .start      (start),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done)
    );

    // PE(i,j): A operand travels east along row i, B^T (same data here) travels south.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (pe_clr) begin
                    acc[i][j] <= 0;
                    pa[i][j]  <= 0;
                    pb[i][j]  <= 0;
                end else begin
                    acc[i][j] <= acc[i][j] + pa[i][j] * pb[i][j];
                    pa[i][j]  <= (j == 0) ? int'(out_data[i*DW +: DW]) : pa[i][j-1];
                    pb[i][j]  <= (i == 0) ? int'(out_data[j*DW +: DW]) : pb[i-1][j];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Column t of the skewed frame: lane i carries A[i][t-i] when that term exists.
    function automatic logic [N*DW-1:0] exp_col(input int t);
        logic [N*DW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (t - i >= 0 && t - i < K) v[i*DW +: DW] = DW'(a_mat[i][t-i]);
        end
        return v;
    endfunction

    task automatic load_matrix(input int mode, input bit start_mid, input bit start_last);
        for (int k = 0; k < K; k++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                load_valid = 1'b0;
                start      = 1'(($urandom_range(0, 1)));
                @(negedge clk);
                check("ready_gap", load_ready, 1);
            end
            for (int i = 0; i < N; i++) begin
                int v;
                v = (mode == 0) ? int'($urandom_range(0, 15)) : (mode == 1) ? 4*i + k + 1 : 15;
                a_mat[i][k] = v;
                load_data[i*DW +: DW] = DW'(v);
            end
            load_valid = 1'b1;
            start      = (start_mid && k == 2) || (start_last && k == K - 1);
            @(negedge clk);
            check("ready_after_beat", load_ready, (k < K - 1));
            check("busy_load", busy, 0);
            check("valid_load", out_valid, 0);
            check("data_load", out_data, 0);
        end
        load_valid = 1'b0;
        start      = 1'b0;
        $display("load: mode=%0d start_mid=%0d start_last=%0d", mode, start_mid, start_last);
    endtask

    task automatic run_frame(input bit noise);
        if (noise) begin
            repeat (3) begin
                load_valid = 1'b1;
                load_data  = N*DW'($urandom);
                start      = 1'b0;
                @(negedge clk);
                check("ready_full", load_ready, 0);
                check("busy_full", busy, 0);
            end
        end
        load_valid = noise;
        load_data  = N*DW'($urandom);
        start      = 1'b1;
        for (int c = 1; c <= K + 2*N + 1; c++) begin
            logic ev;
            logic eb;
            @(negedge clk);
            ev = (c <= K + N - 1);
            eb = (c <= K + 2*N - 1);
            check("out_valid", out_valid, ev);
            check("busy", busy, eb);
            check("done", done, (c == K + 2*N));
            check("load_ready", load_ready, (c >= K + 2*N));
            check("out_data", out_data, ev ? exp_col(c - 1) : '0);
            start      = noise ? 1'(($urandom_range(0, 1))) : 1'b0;
            load_valid = (noise && c < K + 2*N) ? 1'(($urandom_range(0, 1))) : 1'b0;
            load_data  = N*DW'($urandom);
        end
        start      = 1'b0;
        load_valid = 1'b0;
        $display("frame: noise=%0d cycles=%0d", noise, K + 2*N + 1);
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        start      = 1'b0;
        #1;
        check("rst_ready", load_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", load_ready, 1);

        // Fixed pattern A[i][k]=4i+k+1
        load_matrix(1, 1'b0, 1'b0);
        run_frame(1'b0);

        // start in IDLE mid-load and with the last beat is dropped
        load_matrix(0, 1'b1, 1'b1);
        repeat (2) begin
            @(negedge clk);
            check("no_stream_busy", busy, 0);
            check("no_stream_valid", out_valid, 0);
        end
        run_frame(1'b0);

        // load_valid/start noise in FULL, STREAM and DRAIN
        load_matrix(1, 1'b0, 1'b0);
        run_frame(1'b1);

        // Asynchronous reset in STREAM cycle 3
        load_matrix(0, 1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_data", out_data, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", load_ready, 1);
        check("arst_valid", out_valid, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            check("no_done_after_rst", done, 0);
            check("idle_after_rst", busy, 0);
        end
        $display("reset: asserted in stream cycle 3");
        load_matrix(0, 1'b0, 1'b0);
        run_frame(1'b0);

        // Randomized frames
        repeat (3) begin
            load_matrix(0, 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))));
            run_frame(1'(($urandom_range(0, 1))));
        end

        // All-15 operands through the PE array model
        load_matrix(2, 1'b0, 1'b0);
        pe_clr = 1'b0;
        run_frame(1'b0);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                check("pe_acc", acc[i][j], 900);
            end
        end
        $display("pe_array: acc[0][0]=%0d acc[3][3]=%0d", acc[0][0], acc[N-1][N-1]);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
